// File: rtl/vsmac_sched_pkg.sv
// Shared accelerator definitions: scheduler state encoding and the helper
// functions that size the address, step and tile fields.
package vsmac_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Vector memory address width: one word per (tile, step) pair, never zero.
  function automatic int addr_w(input int num_tiles, input int accs);
    int w;
    w = $clog2(num_tiles * accs);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int step_w(input int accs);
    int w;
    w = $clog2(accs);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int tile_w(input int num_tiles);
    int w;
    w = $clog2(num_tiles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vsmac_sched.sv
// Tile scheduler for the vector MAC: clears, steps and drains the datapath per
// tile, then hands each tile result to the consumer over a valid/ready port.
module vsmac_sched
  import vsmac_sched_pkg::*;
#(
  parameter int SIZE          = 6,
  parameter int WIDTH         = 8,
  parameter int ACCUMULATIONS = 3,
  parameter int NUM_TILES     = 4,
  parameter int TIMEOUT       = 15,
  localparam int AW = addr_w(NUM_TILES, ACCUMULATIONS),
  localparam int BW = step_w(ACCUMULATIONS),
  localparam int TW = tile_w(NUM_TILES),
  localparam int DW = WIDTH * SIZE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mac_clear,
  output logic          mac_en,
  output logic [AW-1:0] a_addr,
  output logic [BW-1:0] b_addr,
  input  logic          mac_done,
  input  logic [DW-1:0] mac_out,
  output logic [DW-1:0] res_data,
  output logic [TW-1:0] res_tile,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0]  STEP_LAST = BW'(ACCUMULATIONS - 1);
  localparam logic [TW-1:0]  TILE_LAST = TW'(NUM_TILES - 1);
  localparam logic [TCW-1:0] TCNT_LAST = TCW'(TIMEOUT - 1);
  localparam logic [AW-1:0]  ACC_A     = AW'(ACCUMULATIONS);

  state_t         state_reg;
  logic [BW-1:0]  step_reg;
  logic [TW-1:0]  tile_reg;
  logic [TCW-1:0] tcnt_reg;

  logic           busy_reg;
  logic           done_reg;
  logic           err_reg;
  logic           mac_clear_reg;
  logic           mac_en_reg;
  logic [AW-1:0]  a_addr_reg;
  logic [BW-1:0]  b_addr_reg;
  logic [DW-1:0]  res_data_reg;
  logic [TW-1:0]  res_tile_reg;
  logic           res_valid_reg;

  logic [AW-1:0]  tile_base;
  logic           capture_en;

  assign tile_base = AW'(tile_reg) * ACC_A;

  // Abort outranks a same-cycle mac_done, so capture is suppressed with it.
  assign capture_en = (state_reg == ST_DRAIN) && mac_done && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      step_reg      <= '0;
      tile_reg      <= '0;
      tcnt_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      mac_clear_reg <= 1'b0;
      mac_en_reg    <= 1'b0;
      a_addr_reg    <= '0;
      b_addr_reg    <= '0;
      res_tile_reg  <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort && (state_reg != ST_IDLE)) begin
        state_reg     <= ST_IDLE;
        busy_reg      <= 1'b0;
        mac_clear_reg <= 1'b0;
        mac_en_reg    <= 1'b0;
        res_valid_reg <= 1'b0;
      end else begin
        unique case (state_reg)
          ST_IDLE: begin
            if (start) begin
              tile_reg      <= '0;
              err_reg       <= 1'b0;
              busy_reg      <= 1'b1;
              mac_clear_reg <= 1'b1;
              state_reg     <= ST_CLEAR;
            end
          end

          ST_CLEAR: begin
            mac_clear_reg <= 1'b0;
            mac_en_reg    <= 1'b1;
            step_reg      <= '0;
            b_addr_reg    <= '0;
            a_addr_reg    <= tile_base;
            state_reg     <= ST_RUN;
          end

          ST_RUN: begin
            if (step_reg == STEP_LAST) begin
              mac_en_reg <= 1'b0;
              tcnt_reg   <= '0;
              state_reg  <= ST_DRAIN;
            end else begin
              step_reg   <= step_reg + 1'b1;
              b_addr_reg <= step_reg + 1'b1;
              a_addr_reg <= a_addr_reg + 1'b1;
            end
          end

          ST_DRAIN: begin
            // mac_done is tested first so a completion on the last allowed
            // cycle still wins over the timeout.
            if (mac_done) begin
              res_tile_reg  <= tile_reg;
              res_valid_reg <= 1'b1;
              state_reg     <= ST_OUT;
            end else if (tcnt_reg == TCNT_LAST) begin
              err_reg   <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              tcnt_reg <= tcnt_reg + 1'b1;
            end
          end

          ST_OUT: begin
            if (res_ready) begin
              res_valid_reg <= 1'b0;
              if (tile_reg == TILE_LAST) begin
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= ST_IDLE;
              end else begin
                tile_reg      <= tile_reg + 1'b1;
                mac_clear_reg <= 1'b1;
                state_reg     <= ST_CLEAR;
              end
            end
          end

          default: begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Result register captured lane by lane; each lane holds until the next tile.
  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (reset) begin
          res_data_reg[gi*WIDTH +: WIDTH] <= '0;
        end else if (capture_en) begin
          res_data_reg[gi*WIDTH +: WIDTH] <= mac_out[gi*WIDTH +: WIDTH];
        end
      end
    end
  endgenerate

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign mac_clear = mac_clear_reg;
  assign mac_en    = mac_en_reg;
  assign a_addr    = a_addr_reg;
  assign b_addr    = b_addr_reg;
  assign res_data  = res_data_reg;
  assign res_tile  = res_tile_reg;
  assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_vsmac_sched.sv
// Directed bench for vsmac_sched at default parameters: nominal job,
// backpressure, timeout, abort, reset mid-job and start-while-busy.
module tb_vsmac_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic        mac_clear;
  logic        mac_en;
  logic [3:0]  a_addr;
  logic [1:0]  b_addr;
  logic        mac_done;
  logic [47:0] mac_out;
  logic [47:0] res_data;
  logic [1:0]  res_tile;
  logic        res_valid;
  logic        res_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  vsmac_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mac_clear (mac_clear),
    .mac_en    (mac_en),
    .a_addr    (a_addr),
    .b_addr    (b_addr),
    .mac_done  (mac_done),
    .mac_out   (mac_out),
    .res_data  (res_data),
    .res_tile  (res_tile),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pat(input int t);
    return 48'hA5C3_1E00_0000 + 48'(t) * 48'h0001_0203;
  endfunction

  // Entry: negedge in IDLE. Exit: negedge with the job in CLEAR for tile 0.
  task automatic start_job();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_err_clr", 64'(err), 64'd0);
    check_eq("start_busy", 64'(busy), 64'd1);
  endtask

  // Entry: negedge in CLEAR. Exit: negedge in the first DRAIN cycle.
  task automatic run_to_drain(input int t, input bit poke_start);
    check_eq($sformatf("t%0d_clear", t), 64'(mac_clear), 64'd1);
    check_eq($sformatf("t%0d_clear_en", t), 64'(mac_en), 64'd0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      start = (poke_start && s == 1);
      check_eq($sformatf("t%0d_s%0d_en", t, s), 64'(mac_en), 64'd1);
      check_eq($sformatf("t%0d_s%0d_clr", t, s), 64'(mac_clear), 64'd0);
      check_eq($sformatf("t%0d_s%0d_a", t, s), 64'(a_addr), 64'(3 * t + s));
      check_eq($sformatf("t%0d_s%0d_b", t, s), 64'(b_addr), 64'(s));
    end
    start = 1'b0;
    @(negedge clk);
    check_eq($sformatf("t%0d_drain_en", t), 64'(mac_en), 64'd0);
    check_eq($sformatf("t%0d_drain_vld", t), 64'(res_valid), 64'd0);
  endtask

  task automatic do_tile(input int t, input int drain_wait, input int stall,
                         input bit poke_start, input bit last);
    run_to_drain(t, poke_start);
    for (int d = 0; d < drain_wait; d++) @(negedge clk);
    mac_done = 1'b1;
    mac_out  = pat(t);
    @(negedge clk);
    mac_done = 1'b0;
    mac_out  = ~pat(t);
    check_eq($sformatf("t%0d_vld", t), 64'(res_valid), 64'd1);
    check_eq($sformatf("t%0d_data", t), 64'(res_data), 64'(pat(t)));
    check_eq($sformatf("t%0d_tile", t), 64'(res_tile), 64'(t));
    $display("tile %0d: res_tile=%0d res_data=%h stall=%0d", t, res_tile, res_data, stall);
    if (stall > 0) begin
      res_ready = 1'b0;
      for (int s = 1; s <= stall; s++) begin
        @(negedge clk);
        check_eq($sformatf("t%0d_stall%0d_vld", t, s), 64'(res_valid), 64'd1);
        check_eq($sformatf("t%0d_stall%0d_data", t, s), 64'(res_data), 64'(pat(t)));
        check_eq($sformatf("t%0d_stall%0d_clr", t, s), 64'(mac_clear), 64'd0);
        if (s == stall) res_ready = 1'b1;
      end
    end
    @(negedge clk);
    check_eq($sformatf("t%0d_hs_vld", t), 64'(res_valid), 64'd0);
    if (last) begin
      check_eq("job_done", 64'(done), 64'd1);
      check_eq("job_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check_eq("job_done_pulse", 64'(done), 64'd0);
    end
  endtask

  int base_cnt;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    mac_done = 1'b0; mac_out = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_mac", 64'({mac_clear, mac_en}), 64'd0);
    check_eq("rst_addr", 64'({a_addr, b_addr}), 64'd0);
    check_eq("rst_res", 64'({res_data, res_tile, res_valid}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Nominal job
    start_job();
    for (int t = 0; t < 4; t++) do_tile(t, 2, 0, 1'b0, t == 3);
    check_eq("job1_count", 64'(done_cnt), 64'd1);

    // Backpressure on tile 1, start poked while busy on tile 2
    start_job();
    for (int t = 0; t < 4; t++) do_tile(t, 1, (t == 1) ? 5 : 0, t == 2, t == 3);
    check_eq("job2_count", 64'(done_cnt), 64'd2);

    // Timeout: mac_done never arrives
    start_job();
    run_to_drain(0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i < 15) begin
        check_eq($sformatf("to_wait%0d_busy", i), 64'(busy), 64'd1);
      end else begin
        check_eq("to_err", 64'(err), 64'd1);
        check_eq("to_busy", 64'(busy), 64'd0);
        check_eq("to_done", 64'(done), 64'd0);
        check_eq("to_vld", 64'(res_valid), 64'd0);
      end
    end
    $display("timeout job: err=%0d busy=%0d", err, busy);
    @(negedge clk);
    check_eq("to_err_sticky", 64'(err), 64'd1);
    check_eq("to_count", 64'(done_cnt), 64'd2);

    // Next start clears err; mac_done on the final allowed DRAIN cycle succeeds
    start_job();
    do_tile(0, 14, 0, 1'b0, 1'b0);
    for (int t = 1; t < 4; t++) do_tile(t, 0, 0, 1'b0, t == 3);
    check_eq("job4_count", 64'(done_cnt), 64'd3);

    // Abort during RUN step 1 of tile 2
    start_job();
    do_tile(0, 2, 0, 1'b0, 1'b0);
    do_tile(1, 2, 0, 1'b0, 1'b0);
    check_eq("ab_clear", 64'(mac_clear), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check_eq("ab_step1_a", 64'(a_addr), 64'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("ab_en", 64'(mac_en), 64'd0);
    check_eq("ab_busy", 64'(busy), 64'd0);
    check_eq("ab_clr", 64'(mac_clear), 64'd0);
    check_eq("ab_err", 64'(err), 64'd0);
    $display("abort: busy=%0d mac_en=%0d", busy, mac_en);
    repeat (3) @(negedge clk);
    check_eq("ab_idle_busy", 64'(busy), 64'd0);
    check_eq("ab_count", 64'(done_cnt), 64'd3);

    // Restart from tile 0, then reset while the result is pending
    start_job();
    run_to_drain(0, 1'b0);
    mac_done = 1'b1;
    mac_out  = pat(0);
    @(negedge clk);
    mac_done = 1'b0;
    res_ready = 1'b0;
    check_eq("rs_vld_pre", 64'(res_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rs_busy", 64'(busy), 64'd0);
    check_eq("rs_flags", 64'({done, err}), 64'd0);
    check_eq("rs_mac", 64'({mac_clear, mac_en}), 64'd0);
    check_eq("rs_addr", 64'({a_addr, b_addr}), 64'd0);
    check_eq("rs_res", 64'({res_data, res_tile, res_valid}), 64'd0);
    $display("reset in OUT: res_valid=%0d busy=%0d", res_valid, busy);
    reset = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("final_count", 64'(done_cnt), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
